// File: rtl/mips_gpio_port_pkg.sv
// rtl/mips_gpio_port_pkg.sv - GPIO register offsets and register decode enum
package mips_gpio_port_pkg;

    localparam logic [3:0] GPIO_OFS_OUT    = 4'h0;
    localparam logic [3:0] GPIO_OFS_IN     = 4'h4;
    localparam logic [3:0] GPIO_OFS_STATUS = 4'h8;
    localparam logic [3:0] GPIO_OFS_CFG    = 4'hC;

    // Word index of each register, i.e. addr[3:2]
    typedef enum logic [1:0] {
        REG_OUT    = 2'd0,
        REG_IN     = 2'd1,
        REG_STATUS = 2'd2,
        REG_CFG    = 2'd3
    } gpio_reg_e;

    function automatic gpio_reg_e reg_of_addr(input logic [31:0] addr);
        return gpio_reg_e'(addr[3:2]);
    endfunction

endpackage

// File: rtl/mips_gpio_port_if.sv
// rtl/mips_gpio_port_if.sv - data-memory bus slice seen by the GPIO port
interface mips_gpio_port_if;
    import mips_gpio_port_pkg::*;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output addr, wdata, we, re,
        input  rdata, rvalid
    );

    modport slave (
        input  addr, wdata, we, re,
        output rdata, rvalid
    );

endinterface

// File: rtl/mips_gpio_port_debounce.sv
// rtl/mips_gpio_port_debounce.sv - per-bit debounce of a synchronized input
module gpio_debounce
    import mips_gpio_port_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic change
);

    localparam int            CW   = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // change is high in the cycle whose edge flips q
    assign change = (d != q) && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (d == q) begin
            cnt <= '0;
        end else if (change) begin
            q   <= d;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mips_gpio_port.sv
// rtl/mips_gpio_port.sv - memory-mapped GPIO: sync, debounce, edge capture, output reg
module mips_gpio_port
    import mips_gpio_port_pkg::*;
#(
    parameter logic [31:0]        BASE_ADDR  = 32'h1000_0000,
    parameter int                 GPIO_W     = 8,
    parameter int                 DEB_CYCLES = 4,
    parameter logic [GPIO_W-1:0]  OUT_RESET  = '0
) (
    input  logic              clk,
    input  logic              reset,
    mips_gpio_port_if.slave   bus,
    output logic              irq,
    input  logic [GPIO_W-1:0] GPIO_i,
    output logic [GPIO_W-1:0] GPIO_o
);

    logic [GPIO_W-1:0] sync1, sync2;
    logic [GPIO_W-1:0] deb, deb_chg, deb_next;
    logic [GPIO_W-1:0] out_reg, status, status_next;
    logic [GPIO_W-1:0] cfg_rise, cfg_fall;
    logic [GPIO_W-1:0] rise, fall, w1c;
    logic              sel, wr_en, rd_en;
    gpio_reg_e         ofs;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    assign sel   = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en = bus.we & sel;
    assign rd_en = bus.re & sel;
    assign ofs   = reg_of_addr(bus.addr);

    // Byte lane bits are not decoded; wdata is only partly consumed
    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= GPIO_i;
            sync2 <= sync1;
        end
    end

    for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_deb
        gpio_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .d      (sync2[gi]),
            .q      (deb[gi]),
            .change (deb_chg[gi])
        );
    end

    assign deb_next = deb ^ deb_chg;
    assign rise     = deb_next & ~deb & cfg_rise;
    assign fall     = ~deb_next & deb & cfg_fall;

    // A new edge in the same cycle as its W1C keeps the flag set
    assign w1c         = (wr_en && ofs == REG_STATUS) ? bus.wdata[GPIO_W-1:0] : '0;
    assign status_next = (status & ~w1c) | rise | fall;

    always_comb begin
        rd_mux = '0;
        unique case (ofs)
            REG_OUT:    rd_mux[GPIO_W-1:0] = out_reg;
            REG_IN:     rd_mux[GPIO_W-1:0] = deb;
            REG_STATUS: rd_mux[GPIO_W-1:0] = status;
            REG_CFG: begin
                rd_mux[GPIO_W-1:0]  = cfg_rise;
                rd_mux[GPIO_W+15:16] = cfg_fall;
            end
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg    <= OUT_RESET;
            cfg_rise   <= '0;
            cfg_fall   <= '0;
            status     <= '0;
            irq        <= 1'b0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            status     <= status_next;
            irq        <= |status_next;
            bus.rvalid <= rd_en;
            // rd_mux sees pre-write state, so a combined load+store reads the old value
            if (rd_en) begin
                bus.rdata <= rd_mux;
            end
            if (wr_en) begin
                case (ofs)
                    REG_OUT: out_reg <= bus.wdata[GPIO_W-1:0];
                    REG_CFG: begin
                        cfg_rise <= bus.wdata[GPIO_W-1:0];
                        cfg_fall <= bus.wdata[GPIO_W+15:16];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign GPIO_o = out_reg;

endmodule

// File: tb/tb_mips_gpio_port.sv
// tb/tb_mips_gpio_port.sv - directed self-checking bench for mips_gpio_port
module tb_mips_gpio_port;
    import mips_gpio_port_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic       irq;
    logic [7:0] gpio_i;
    logic [7:0] gpio_o;

    int checks   = 0;
    int failures = 0;

    mips_gpio_port_if bus ();

    mips_gpio_port #(
        .BASE_ADDR  (BASE),
        .GPIO_W     (8),
        .DEB_CYCLES (4),
        .OUT_RESET  (8'hA5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .irq    (irq),
        .GPIO_i (gpio_i),
        .GPIO_o (gpio_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic        exp_v;
        logic [31:0] exp_rd;
        logic [7:0]  exp_o;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(negedge clk);
        bus.we    = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        @(negedge clk);
        bus.addr = a;
        bus.re   = 1'b1;
        @(posedge clk);
        #1;
        d = bus.rdata;
        v = bus.rvalid;
        @(negedge clk);
        bus.re = 1'b0;
        chk({name, " rvalid"}, {31'd0, v}, 32'd1);
        chk(name, d, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_rd;

        reset     = 1'b1;
        gpio_i    = 8'h00;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.we    = 1'b0;
        bus.re    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset GPIO_o", {24'd0, gpio_o}, 32'hA5);
        chk("reset irq", {31'd0, irq}, 32'd0);
        chk("reset rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("reset rdata", bus.rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("reset IN", BASE + 32'(GPIO_OFS_IN), 32'd0);

        // Register access table, applied back to back
        vecs[0]  = '{BASE + 32'h0,  32'h0000_003C, 1, 0, 0, 32'h0,         8'h3C};
        vecs[1]  = '{BASE + 32'h0,  32'h0,         0, 1, 1, 32'h3C,        8'h3C};
        vecs[2]  = '{BASE + 32'h4,  32'h0000_00FF, 1, 0, 0, 32'h0,         8'h3C};
        vecs[3]  = '{BASE + 32'h4,  32'h0,         0, 1, 1, 32'h0,         8'h3C};
        vecs[4]  = '{BASE + 32'hC,  32'hFFFF_FFFF, 1, 0, 0, 32'h0,         8'h3C};
        vecs[5]  = '{BASE + 32'hF,  32'h0,         0, 1, 1, 32'h00FF_00FF, 8'h3C};
        vecs[6]  = '{BASE + 32'h20, 32'h0000_0055, 1, 0, 0, 32'h0,         8'h3C};
        vecs[7]  = '{BASE + 32'h0,  32'h0,         0, 1, 1, 32'h3C,        8'h3C};
        vecs[8]  = '{BASE + 32'h20, 32'h0,         0, 1, 0, 32'h0,         8'h3C};
        vecs[9]  = '{BASE + 32'h0,  32'h0000_005A, 1, 1, 1, 32'h3C,        8'h5A};
        vecs[10] = '{BASE + 32'h0,  32'h0,         0, 1, 1, 32'h5A,        8'h5A};
        vecs[11] = '{BASE + 32'h2C, 32'h0,         1, 0, 0, 32'h0,         8'h5A};
        vecs[12] = '{BASE + 32'hC,  32'h0,         0, 1, 1, 32'h00FF_00FF, 8'h5A};
        vecs[13] = '{BASE + 32'hC,  32'h0080_0001, 1, 0, 0, 32'h0,         8'h5A};
        vecs[14] = '{BASE + 32'hC,  32'h0,         0, 1, 1, 32'h0080_0001, 8'h5A};
        vecs[15] = '{BASE + 32'h1,  32'h0000_003C, 1, 0, 0, 32'h0,         8'h3C};

        last_rd = 32'd0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.addr  = vecs[i].addr;
            bus.wdata = vecs[i].wdata;
            bus.we    = vecs[i].we;
            bus.re    = vecs[i].re;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d rvalid", i), {31'd0, bus.rvalid}, {31'd0, vecs[i].exp_v});
            if (vecs[i].exp_v) last_rd = vecs[i].exp_rd;
            chk($sformatf("vec%0d rdata", i), bus.rdata, last_rd);
            chk($sformatf("vec%0d GPIO_o", i), {24'd0, gpio_o}, {24'd0, vecs[i].exp_o});
        end
        @(negedge clk);
        bus.we = 1'b0;
        bus.re = 1'b0;
        @(posedge clk);
        #1;
        chk("rvalid drops", {31'd0, bus.rvalid}, 32'd0);

        // 3-cycle glitch on bit 0 never reaches IN
        @(negedge clk);
        gpio_i   = 8'h01;
        bus.addr = BASE + 32'(GPIO_OFS_IN);
        bus.re   = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin
                @(negedge clk);
                gpio_i = 8'h00;
            end
            chk($sformatf("glitch IN k=%0d", k), bus.rdata, 32'd0);
            chk($sformatf("glitch irq k=%0d", k), {31'd0, irq}, 32'd0);
        end
        @(negedge clk);
        bus.re = 1'b0;
        rd_chk("glitch STATUS", BASE + 32'(GPIO_OFS_STATUS), 32'd0);

        // Stable rise: deb flips on edge 6, seen by a read after edge 7
        @(negedge clk);
        gpio_i   = 8'h01;
        bus.addr = BASE + 32'(GPIO_OFS_IN);
        bus.re   = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rise IN k=%0d", k), bus.rdata, (k >= 7) ? 32'd1 : 32'd0);
            if (k <= 5) chk($sformatf("rise irq k=%0d", k), {31'd0, irq}, 32'd0);
            if (k >= 7) chk($sformatf("rise irq k=%0d", k), {31'd0, irq}, 32'd1);
        end
        @(negedge clk);
        bus.re = 1'b0;
        rd_chk("rise STATUS", BASE + 32'(GPIO_OFS_STATUS), 32'h01);

        // Clear, then falling edge on bit 7 only is captured
        bus_wr(BASE + 32'(GPIO_OFS_STATUS), 32'hFF);
        @(posedge clk);
        #1;
        chk("w1c all irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        gpio_i = 8'hFF;
        repeat (10) @(posedge clk);
        rd_chk("FF STATUS", BASE + 32'(GPIO_OFS_STATUS), 32'd0);
        rd_chk("FF IN", BASE + 32'(GPIO_OFS_IN), 32'hFF);
        @(negedge clk);
        gpio_i = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k <= 5) chk($sformatf("fall irq k=%0d", k), {31'd0, irq}, 32'd0);
            if (k >= 7) chk($sformatf("fall irq k=%0d", k), {31'd0, irq}, 32'd1);
        end
        rd_chk("fall STATUS", BASE + 32'(GPIO_OFS_STATUS), 32'h80);

        // W1C of all bits on the very edge a bit-0 rise resolves
        @(negedge clk);
        gpio_i = 8'h01;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.addr  = BASE + 32'(GPIO_OFS_STATUS);
        bus.wdata = 32'hFF;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        chk("race irq edge", {31'd0, irq}, 32'd1);
        @(negedge clk);
        bus.we = 1'b0;
        @(posedge clk);
        #1;
        chk("race irq after", {31'd0, irq}, 32'd1);
        rd_chk("race STATUS", BASE + 32'(GPIO_OFS_STATUS), 32'h01);
        bus_wr(BASE + 32'(GPIO_OFS_STATUS), 32'h01);
        @(posedge clk);
        #1;
        chk("w1c bit0 irq", {31'd0, irq}, 32'd0);
        rd_chk("w1c bit0 STATUS", BASE + 32'(GPIO_OFS_STATUS), 32'd0);

        // Reset in the middle of a debounce count
        @(negedge clk);
        gpio_i = 8'h00;
        repeat (10) @(posedge clk);
        rd_chk("pre-reset IN", BASE + 32'(GPIO_OFS_IN), 32'd0);
        @(negedge clk);
        gpio_i = 8'h01;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async reset GPIO_o", {24'd0, gpio_o}, 32'hA5);
        chk("async reset irq", {31'd0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        bus.addr = BASE + 32'(GPIO_OFS_IN);
        bus.re   = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-reset IN k=%0d", k), bus.rdata, (k >= 7) ? 32'd1 : 32'd0);
            chk($sformatf("post-reset irq k=%0d", k), {31'd0, irq}, 32'd0);
        end
        @(negedge clk);
        bus.re = 1'b0;
        rd_chk("post-reset STATUS", BASE + 32'(GPIO_OFS_STATUS), 32'd0);
        rd_chk("post-reset CFG", BASE + 32'(GPIO_OFS_CFG), 32'd0);
        rd_chk("post-reset OUT", BASE + 32'(GPIO_OFS_OUT), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
